// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and the fetch-entry record for the fetch unit.
package fetch_pkg;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 2;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular buffer of fetched {pc, inst} entries.
// Flush clears pointers and count only; storage is zeroed just by reset.
module fetch_fifo import fetch_pkg::*; #(
    parameter int W     = DEF_ADDR_W + DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic [W-1:0]  dout
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;

    assign count = count_q;
    assign dout  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and fetch control feeding a small decode buffer.
// The instruction memory sits outside; it answers adressIM combinationally on inst.
module fetch_unit import fetch_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] adressIM,
    input  logic [DATA_W-1:0] inst,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     push, pop;
    logic [CW-1:0]            count;
    logic [ADDR_W+DATA_W-1:0] head;

    assign adressIM  = pc_q;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    // A full buffer still accepts a fetch when the head leaves this cycle.
    assign push      = !halt && !redirect_valid && (count < CW'(DEPTH) || pop);
    assign {out_pc, out_inst} = head;

    always_comb pc_d = redirect_valid ? redirect_pc : push ? pc_q + ADDR_W'(1) : pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    fetch_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({pc_q, inst}),
        .count (count),
        .dout  (head)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a queue model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [4:0]  adressIM;
    logic [31:0] inst;
    logic        halt = 0;
    logic        redirect_valid = 0;
    logic [4:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_inst;
    logic [4:0]  out_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [4:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    assign inst = imem(adressIM);

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adressIM       (adressIM),
        .inst           (inst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit       rst_n, halt, redir;
        bit [4:0] rpc;
        bit       ready;
        bit       ev;
        bit [4:0] epc, eaddr;
    } vec_t;

    function automatic vec_t mk(bit r, bit h, bit rd, bit [4:0] rp, bit rdy,
                                bit ev, bit [4:0] epc, bit [4:0] ea);
        vec_t v;
        v.rst_n = r; v.halt = h; v.redir = rd; v.rpc = rp; v.ready = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = ea;
        return v;
    endfunction

    // model state
    fetch_entry_t q[$];
    logic [4:0]   mpc;

    task automatic model_edge();
        bit p, u;
        if (!rst_n) begin
            q.delete();
            mpc = 0;
        end else if (redirect_valid) begin
            q.delete();
            mpc = redirect_pc;
        end else begin
            p = (q.size() > 0) && out_ready;
            u = !halt && (q.size() < 2 || p);
            if (p) void'(q.pop_front());
            if (u) begin
                q.push_back('{pc: mpc, inst: imem(mpc)});
                mpc = mpc + 5'd1;
            end
        end
    endtask

    initial begin
        vec_t tbl[23];
        // reset, then decode stalled for 5 cycles: two fetches fill the buffer
        tbl[0]  = mk(0,0,0, 0,0, 0, 0, 0);
        tbl[1]  = mk(1,0,0, 0,0, 1, 0, 1);
        tbl[2]  = mk(1,0,0, 0,0, 1, 0, 2);
        tbl[3]  = mk(1,0,0, 0,0, 1, 0, 2);
        tbl[4]  = mk(1,0,0, 0,0, 1, 0, 2);
        tbl[5]  = mk(1,0,0, 0,0, 1, 0, 2);
        tbl[6]  = mk(1,0,0, 0,1, 1, 1, 3);
        tbl[7]  = mk(1,0,0, 0,1, 1, 2, 4);
        // redirect with a full buffer
        tbl[8]  = mk(1,0,1,20,1, 0, 0,20);
        tbl[9]  = mk(1,0,0, 0,1, 1,20,21);
        tbl[10] = mk(1,0,0, 0,1, 1,21,22);
        tbl[11] = mk(1,0,0, 0,0, 1,21,23);
        // halt drains two entries in order
        tbl[12] = mk(1,1,0, 0,1, 1,22,23);
        tbl[13] = mk(1,1,0, 0,1, 0, 0,23);
        tbl[14] = mk(1,1,0, 0,1, 0, 0,23);
        // wrap from 30
        tbl[15] = mk(1,0,1,30,1, 0, 0,30);
        tbl[16] = mk(1,0,0, 0,1, 1,30,31);
        tbl[17] = mk(1,0,0, 0,1, 1,31, 0);
        tbl[18] = mk(1,0,0, 0,1, 1, 0, 1);
        tbl[19] = mk(1,0,0, 0,1, 1, 1, 2);
        // fill, then reset mid-stream
        tbl[20] = mk(1,0,0, 0,0, 1, 1, 3);
        tbl[21] = mk(0,0,1, 9,1, 0, 0, 0);
        tbl[22] = mk(1,0,0, 0,1, 1, 0, 1);

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            rst_n = tbl[i].rst_n; halt = tbl[i].halt; redirect_valid = tbl[i].redir;
            redirect_pc = tbl[i].rpc; out_ready = tbl[i].ready;
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d adressIM", i), 32'(adressIM), 32'(tbl[i].eaddr));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d out_pc", i), 32'(out_pc), 32'(tbl[i].epc));
                chk($sformatf("vec%0d out_inst", i), out_inst, imem(tbl[i].epc));
            end
            if (!tbl[i].rst_n) begin
                chk($sformatf("vec%0d rst out_pc", i), 32'(out_pc), 32'h0);
                chk($sformatf("vec%0d rst out_inst", i), out_inst, 32'h0);
            end
            @(negedge clk);
        end

        // randomized run against the queue model
        rst_n = 0; halt = 0; redirect_valid = 0; out_ready = 0;
        @(posedge clk); #1;
        model_edge();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n          = ($urandom_range(0, 99) >= 2);
            halt           = ($urandom_range(0, 99) < 25);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = 5'($urandom);
            out_ready      = ($urandom_range(0, 99) < 65);
            chk("rnd out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd adressIM", 32'(adressIM), 32'(mpc));
            if (q.size() != 0) begin
                chk("rnd out_pc", 32'(out_pc), 32'(q[0].pc));
                chk("rnd out_inst", out_inst, q[0].inst);
            end
            @(posedge clk); #1;
            model_edge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
